// File: rtl/fifo_chk_pkg.sv
// Shared types and elaboration helpers for the FIFO scoreboard checker.
package fifo_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } chk_state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_TAG_W  = $clog2(DEF_DEPTH) + 1;

  // Tagged shadow entry at the default geometry; modules rebuild it from their own parameters.
  typedef struct packed {
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DATA_W-1:0] data;
  } chk_entry_t;

  function automatic bit read_lat_ok(input int lat);
    return (lat == 0) || (lat == 1);
  endfunction

endpackage

// File: rtl/fifo_chk_shadow.sv
// Tagged shadow copy of the FIFO under check: storage, pointers, tag counter and occupancy.
module fifo_chk_shadow
  import fifo_chk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [TAG_W-1:0]        occupancy,
  output logic [TAG_W-1:0]        wr_tag,
  output logic [TAG_W+DATA_W-1:0] rd_entry
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array is deliberately left out of reset; its contents are never
  // read before being written, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'{tag: wr_tag, data: wr_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_tag    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        wr_tag <= wr_tag + TAG_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occupancy <= occupancy + TAG_W'(1);
      else if (pop && !push) occupancy <= occupancy - TAG_W'(1);
    end
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/fifo_scoreboard_chk.sv
// Scoreboard checker bound beside a single-clock FIFO: predicts pop data, checks flags,
// and reports sticky errors, first-mismatch capture, checker state and matched-pop count.
module fifo_scoreboard_chk
  import fifo_chk_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int READ_LAT = 1,
  parameter  int BYPASS   = 1,
  parameter  int STAT_W   = 16,
  localparam int TAG_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_vld,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              dut_full,
  input  logic              dut_empty,
  output logic [TAG_W-1:0]  occupancy,
  output logic [1:0]        chk_state,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_mismatch,
  output logic              err_flag,
  output logic              err_any,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [TAG_W-1:0]  fail_tag,
  output logic [STAT_W-1:0] pop_cnt
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  chk_state_e       state;
  logic [TAG_W-1:0] wr_tag;
  entry_t           rd_entry;
  entry_t           pred;
  entry_t           cmp_pred;
  logic             cmp_vld;
  logic             push_ok, pop_ok;
  logic             ovf_ev, udf_ev, mis_ev, flag_ev, err_ev, pop_match, first_mis;

  assign push_ok = wr_vld && ((occupancy < TAG_W'(DEPTH)) || rd_vld);
  assign pop_ok  = rd_vld && ((occupancy != '0) || ((BYPASS != 0) && wr_vld));

  fifo_chk_shadow #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok),
    .pop      (pop_ok),
    .wr_data  (wr_data),
    .occupancy(occupancy),
    .wr_tag   (wr_tag),
    .rd_entry (rd_entry)
  );

  // An empty shadow can only be popped through bypass, which returns the word being pushed.
  assign pred = (occupancy != '0) ? rd_entry : entry_t'{tag: wr_tag, data: wr_data};

  generate
    if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
      $fatal(1, "fifo_scoreboard_chk: READ_LAT must be 0 or 1");
    end
    if (READ_LAT == 0) begin : g_lat0
      assign cmp_vld  = pop_ok;
      assign cmp_pred = pred;
    end else begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmp_vld  <= 1'b0;
          cmp_pred <= '0;
        end else begin
          cmp_vld  <= pop_ok;
          cmp_pred <= pred;
        end
      end
    end
  endgenerate

  assign ovf_ev    = wr_vld && !push_ok;
  assign udf_ev    = rd_vld && !pop_ok;
  assign mis_ev    = cmp_vld && (rd_data != cmp_pred.data);
  assign pop_match = cmp_vld && !mis_ev;
  assign flag_ev   = ((state != IDLE) || (occupancy != '0)) &&
                     ((dut_full != (occupancy == TAG_W'(DEPTH))) || (dut_empty != (occupancy == '0)));
  assign err_ev    = ovf_ev || udf_ev || mis_ev || flag_ev;
  assign first_mis = mis_ev && (clr || !err_mismatch);

  // Error events take priority over a coincident clr, both for sticky bits and captures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_mismatch  <= 1'b0;
      err_flag      <= 1'b0;
      fail_exp      <= '0;
      fail_act      <= '0;
      fail_tag      <= '0;
      pop_cnt       <= '0;
    end else begin
      err_overflow  <= ovf_ev  || (err_overflow  && !clr);
      err_underflow <= udf_ev  || (err_underflow && !clr);
      err_mismatch  <= mis_ev  || (err_mismatch  && !clr);
      err_flag      <= flag_ev || (err_flag      && !clr);

      if (first_mis) begin
        fail_exp <= cmp_pred.data;
        fail_act <= rd_data;
        fail_tag <= cmp_pred.tag;
      end else if (clr) begin
        fail_exp <= '0;
        fail_act <= '0;
        fail_tag <= '0;
      end

      if (clr)                          pop_cnt <= '0;
      else if (pop_match && !(&pop_cnt)) pop_cnt <= pop_cnt + STAT_W'(1);

      if (err_ev) state <= FAIL;
      else begin
        case (state)
          IDLE:    if (push_ok) state <= RUN;
          RUN:     state <= RUN;
          FAIL:    if (clr) state <= (occupancy != '0) ? RUN : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign chk_state = state;
  assign err_any   = err_overflow || err_underflow || err_mismatch || err_flag;

endmodule

// File: tb/tb_fifo_scoreboard_chk.sv
// Self-checking bench: constant-expectation vectors and sequences plus a queue-based reference model.
module tb_fifo_scoreboard_chk;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int TW    = 3;
  localparam int SW    = 16;

  logic          clk = 1'b0;
  logic          rst, clr, wr_vld, rd_vld, dut_full, dut_empty;
  logic [DW-1:0] wr_data, rd_data;

  logic [TW-1:0] occupancy, fail_tag, nb_occupancy, nb_fail_tag;
  logic [1:0]    chk_state, nb_chk_state;
  logic          err_overflow, err_underflow, err_mismatch, err_flag, err_any;
  logic          nb_err_overflow, nb_err_underflow, nb_err_mismatch, nb_err_flag, nb_err_any;
  logic [DW-1:0] fail_exp, fail_act, nb_fail_exp, nb_fail_act;
  logic [SW-1:0] pop_cnt, nb_pop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_scoreboard_chk #(.DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(1), .BYPASS(1), .STAT_W(SW)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_vld(wr_vld), .wr_data(wr_data),
    .rd_vld(rd_vld), .rd_data(rd_data), .dut_full(dut_full), .dut_empty(dut_empty),
    .occupancy(occupancy), .chk_state(chk_state), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .err_mismatch(err_mismatch), .err_flag(err_flag),
    .err_any(err_any), .fail_exp(fail_exp), .fail_act(fail_act), .fail_tag(fail_tag),
    .pop_cnt(pop_cnt)
  );

  fifo_scoreboard_chk #(.DATA_W(DW), .DEPTH(DEPTH), .READ_LAT(1), .BYPASS(0), .STAT_W(SW)) u_nobyp (
    .clk(clk), .rst(rst), .clr(clr), .wr_vld(wr_vld), .wr_data(wr_data),
    .rd_vld(rd_vld), .rd_data(rd_data), .dut_full(dut_full), .dut_empty(dut_empty),
    .occupancy(nb_occupancy), .chk_state(nb_chk_state), .err_overflow(nb_err_overflow),
    .err_underflow(nb_err_underflow), .err_mismatch(nb_err_mismatch), .err_flag(nb_err_flag),
    .err_any(nb_err_any), .fail_exp(nb_fail_exp), .fail_act(nb_fail_act), .fail_tag(nb_fail_tag),
    .pop_cnt(nb_pop_cnt)
  );

  // Reference model: the FIFO contents as a queue of {tag,data}, plus the spec's sticky state.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          m_q[$];
  int            m_tag, m_state, m_pc;
  bit            m_pv;
  ent_t          m_pe;
  bit            m_ovf, m_udf, m_mis, m_flag;
  logic [DW-1:0] m_fexp, m_fact;
  logic [TW-1:0] m_ftag;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tag = 0; m_state = 0; m_pc = 0; m_pv = 0; m_pe = '0;
    m_ovf = 0; m_udf = 0; m_mis = 0; m_flag = 0;
    m_fexp = '0; m_fact = '0; m_ftag = '0;
  endtask

  task automatic model_step();
    int   sz;
    bit   push_ok, pop_ok, mis, match, flg, ovf, udf, ev, first;
    ent_t pred;
    sz      = m_q.size();
    push_ok = wr_vld && (sz < DEPTH || rd_vld);
    pop_ok  = rd_vld && (sz > 0 || wr_vld);
    pred.tag  = m_tag[TW-1:0];
    pred.data = wr_data;
    if (sz > 0) pred = m_q[0];
    mis   = m_pv && (rd_data !== m_pe.data);
    match = m_pv && !mis;
    flg   = (m_state != 0 || sz > 0) && ((dut_full != (sz == DEPTH)) || (dut_empty != (sz == 0)));
    ovf   = wr_vld && !push_ok;
    udf   = rd_vld && !pop_ok;
    ev    = ovf || udf || mis || flg;
    first = mis && (clr || !m_mis);
    m_ovf  = ovf || (m_ovf  && !clr);
    m_udf  = udf || (m_udf  && !clr);
    m_mis  = mis || (m_mis  && !clr);
    m_flag = flg || (m_flag && !clr);
    if (first) begin
      m_fexp = m_pe.data; m_fact = rd_data; m_ftag = m_pe.tag;
    end else if (clr) begin
      m_fexp = '0; m_fact = '0; m_ftag = '0;
    end
    if (clr) m_pc = 0;
    else if (match && m_pc < (1 << SW) - 1) m_pc++;
    if (ev) m_state = 2;
    else if (m_state == 0 && push_ok) m_state = 1;
    else if (m_state == 2 && clr) m_state = (sz > 0) ? 1 : 0;
    if (push_ok) begin
      m_q.push_back(ent_t'{tag: m_tag[TW-1:0], data: wr_data});
      m_tag = (m_tag + 1) % (1 << TW);
    end
    if (pop_ok) void'(m_q.pop_front());
    m_pv = pop_ok;
    m_pe = pred;
  endtask

  task automatic check_model();
    check("occupancy",     32'(occupancy),     m_q.size());
    check("chk_state",     32'(chk_state),     m_state);
    check("err_overflow",  32'(err_overflow),  32'(m_ovf));
    check("err_underflow", 32'(err_underflow), 32'(m_udf));
    check("err_mismatch",  32'(err_mismatch),  32'(m_mis));
    check("err_flag",      32'(err_flag),      32'(m_flag));
    check("err_any",       32'(err_any),       32'(m_ovf | m_udf | m_mis | m_flag));
    check("fail_exp",      32'(fail_exp),      32'(m_fexp));
    check("fail_act",      32'(fail_act),      32'(m_fact));
    check("fail_tag",      32'(fail_tag),      32'(m_ftag));
    check("pop_cnt",       32'(pop_cnt),       m_pc);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_occ"},   32'(occupancy), 0);
    check({nm, "_state"}, 32'(chk_state), 0);
    check({nm, "_errs"},  32'({err_overflow, err_underflow, err_mismatch, err_flag, err_any}), 0);
    check({nm, "_fail"},  32'({fail_exp, fail_act, fail_tag}), 0);
    check({nm, "_pcnt"},  32'(pop_cnt), 0);
  endtask

  // One clock cycle: drive inputs, advance the model, then sample 1 time unit after the edge.
  task automatic cycle(input bit wv, input logic [DW-1:0] wd, input bit rv, input logic [DW-1:0] rd,
                       input bit full, input bit empty, input bit c);
    wr_vld = wv; wr_data = wd; rd_vld = rv; rd_data = rd;
    dut_full = full; dut_empty = empty; clr = c;
    model_step();
    @(posedge clk); #1;
    check_model();
  endtask

  function automatic logic [DW-1:0] good_rd();
    return m_pv ? m_pe.data : '0;
  endfunction

  // Well-behaved DUT: correct flags and correct read data for the previous pop.
  task automatic op(input bit wv, input logic [DW-1:0] wd, input bit rv, input bit c);
    cycle(wv, wd, rv, good_rd(), m_q.size() == DEPTH, m_q.size() == 0, c);
  endtask

  task automatic apply_reset();
    rst = 1'b1; clr = 0; wr_vld = 0; rd_vld = 0; wr_data = '0; rd_data = '0;
    dut_full = 0; dut_empty = 1;
    model_reset();
    #1 check_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit            wv;
    logic [DW-1:0] wd;
    bit            rv;
    logic [DW-1:0] rd;
    bit            full;
    bit            empty;
    int            occ;
    int            pc;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [DW-1:0] r_wd, r_rd;
    bit            r_wv, r_rv, r_full, r_empty, r_clr;

    vt[0] = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 1, 0};
    vt[1] = '{1'b1, 4'h7, 1'b0, 4'h0, 1'b0, 1'b0, 2, 0};
    vt[2] = '{1'b1, 4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 3, 0};
    vt[3] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4, 0};
    vt[4] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 3, 0};
    vt[5] = '{1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 1'b0, 2, 1};
    vt[6] = '{1'b0, 4'h0, 1'b1, 4'h7, 1'b0, 1'b0, 1, 2};
    vt[7] = '{1'b0, 4'h0, 1'b1, 4'hA, 1'b0, 1'b0, 0, 3};
    vt[8] = '{1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b1, 0, 4};

    apply_reset();

    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].wv, vt[i].wd, vt[i].rv, vt[i].rd, vt[i].full, vt[i].empty, 1'b0);
      check("tbl_occ",     32'(occupancy), vt[i].occ);
      check("tbl_pop_cnt", 32'(pop_cnt),   vt[i].pc);
      check("tbl_state",   32'(chk_state), 1);
      check("tbl_err_any", 32'(err_any),   0);
    end

    // First mismatch captured; a later mismatch leaves the capture alone.
    apply_reset();
    op(1, 4'h5, 0, 0);
    op(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 0, 4'h6, 0, 1, 0);
    check("mis_flag", 32'(err_mismatch), 1);
    check("mis_exp",  32'(fail_exp), 32'h5);
    check("mis_act",  32'(fail_act), 32'h6);
    check("mis_tag",  32'(fail_tag), 0);
    check("mis_state", 32'(chk_state), 2);
    op(1, 4'h2, 0, 0);
    op(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 0, 4'h1, 0, 1, 0);
    check("mis2_exp", 32'(fail_exp), 32'h5);
    check("mis2_act", 32'(fail_act), 32'h6);
    check("mis2_tag", 32'(fail_tag), 0);

    // Overflow at full, clr back to RUN, then a legal push+pop at full.
    apply_reset();
    for (int i = 1; i <= 4; i++) op(1, 4'(i), 0, 0);
    op(1, 4'hE, 0, 0);
    check("ovf_flag", 32'(err_overflow), 1);
    check("ovf_occ",  32'(occupancy), 4);
    op(0, 4'h0, 0, 1);
    check("ovf_clr_state", 32'(chk_state), 1);
    check("ovf_clr_err",   32'(err_any), 0);
    op(1, 4'h8, 1, 0);
    check("full_pp_err", 32'(err_any), 0);
    check("full_pp_occ", 32'(occupancy), 4);
    op(0, 4'h0, 0, 0);
    check("full_pp_pcnt", 32'(pop_cnt), 1);

    // Bypass pop on empty: legal with BYPASS=1, underflow with BYPASS=0.
    apply_reset();
    op(1, 4'h9, 1, 0);
    check("byp_udf",    32'(err_underflow), 0);
    check("byp_occ",    32'(occupancy), 0);
    check("nobyp_udf",  32'(nb_err_underflow), 1);
    check("nobyp_occ",  32'(nb_occupancy), 1);
    cycle(0, 4'h0, 0, 4'h9, 0, 1, 0);
    check("byp_pcnt",    32'(pop_cnt), 1);
    check("byp_err_any", 32'(err_any), 0);

    // DUT keeps dut_empty high after a push; clr with one entry returns to RUN.
    apply_reset();
    op(1, 4'h4, 0, 0);
    cycle(0, 4'h0, 0, 4'h0, 0, 1, 0);
    check("flag_err",   32'(err_flag), 1);
    check("flag_state", 32'(chk_state), 2);
    op(0, 4'h0, 0, 1);
    check("flag_clr_err",   32'(err_any), 0);
    check("flag_clr_state", 32'(chk_state), 1);

    // Push/pop pairs with an asynchronous reset mid-stream after the 5th push.
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      op(1, 4'(i + 2), 0, 0);
      if (i == 4) begin
        check("pre_rst_pcnt", 32'(pop_cnt), 4);
        #3 rst = 1'b1;
        #1 check_reset("async_rst");
        @(posedge clk); #1;
        check_reset("held_rst");
        rst = 1'b0;
        model_reset();
      end else begin
        op(0, 4'h0, 1, 0);
      end
    end
    op(0, 4'h0, 0, 0);
    check("restart_pcnt", 32'(pop_cnt), 4);
    check("restart_err",  32'(err_any), 0);
    op(1, 4'hC, 0, 0);
    op(0, 4'h0, 1, 0);
    cycle(0, 4'h0, 0, 4'h3, 0, 1, 0);
    check("restart_tag", 32'(fail_tag), 4);
    check("restart_exp", 32'(fail_exp), 32'hC);

    // Randomized traffic with occasional corrupt data, wrong flags and clears.
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      r_wv    = ($urandom_range(0, 99) < 55);
      r_rv    = ($urandom_range(0, 99) < 50);
      r_wd    = 4'($urandom_range(0, 15));
      r_rd    = good_rd();
      if ($urandom_range(0, 19) == 0) r_rd = r_rd ^ 4'($urandom_range(1, 15));
      r_full  = (m_q.size() == DEPTH);
      r_empty = (m_q.size() == 0);
      if ($urandom_range(0, 39) == 0) r_full  = !r_full;
      if ($urandom_range(0, 39) == 0) r_empty = !r_empty;
      r_clr   = ($urandom_range(0, 24) == 0);
      cycle(r_wv, r_wd, r_rv, r_rd, r_full, r_empty, r_clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
